flight_call_button_fsm: RTL and testbench
=========================================

Name: flight_call_button_fsm

Overview:
Passenger flight-attendant call-button controller for the cabin-seat panel. A "call" press lights the attendant indicator L. L stays lit until a "cancel" press clears it. Call has priority over cancel. Optional input synchronizer stages allow the block to accept asynchronous button lines directly from panel switches.

Parameters:
SYNC_STAGES, 0, number of flip-flop synchronizer stages on each of call and cncl (0 = inputs used directly, already synchronous; legal 0..3).

Ports:
clk  input  1  system clock; all state updates on rising edge.
rst  input  1  asynchronous, active-low reset (rst=0 resets immediately, independent of clk; release synchronous to design use).
call  input  1  call button, active-high level; high while pressed.
cncl  input  1  cancel button, active-high level; high while pressed.
L  output  1  call light, active-high; driven directly from state register (glitch-free, Moore).

Behaviour:
- Reset: while rst=0, state=OFF, L=0, all synchronizer flops=0. Reset assertion mid-operation forces L=0 asynchronously; after release FSM starts in OFF.
- States: OFF (L=0), ON (L=1). Two-state Moore machine, single state bit or enum; no other reachable states; illegal encodings recover to OFF on next edge.
- Internal signals: call_s, cncl_s = call/cncl after SYNC_STAGES flops (pass-through when 0).
- Next-state rule, evaluated each rising clk:
  - call_s=1 -> ON (from either state; call wins when call_s=cncl_s=1).
  - call_s=0, cncl_s=1 -> OFF.
  - call_s=0, cncl_s=0 -> hold current state.
- Latency: with SYNC_STAGES=0, L changes on the first rising edge at which the input is sampled high (one-cycle register latency). Each synchronizer stage adds one cycle.
- Level-sensitive, not edge-detected: holding call keeps L=1. Holding cncl keeps L=0 once call releases. Repeated call while ON has no effect. cncl while OFF has no effect.
- Pulses shorter than one clock period that miss a rising edge are ignored.
- No counters, no timeouts; L remains ON indefinitely until cancel or reset.

Test Plan:
- Reset: rst=0 for 20 ns with call=1 -> L=0 throughout reset; after rst=1, L=1 at the next rising edge (SYNC_STAGES=0).
- Call/hold: 10 ns clock, call=1 for 50 ns then 0 for 100 ns, cncl=0 -> L rises at the first edge after call, stays 1 for the whole 100 ns idle.
- Cancel: from ON, cncl=1 for 50 ns, call=0 -> L=0 at the first edge sampling cncl; stays 0 after cncl drops.
- Priority: call=1 and cncl=1 simultaneously from OFF and from ON -> L=1 in both cases; releasing call with cncl still 1 -> L=0 next edge.
- No-ops: cncl=1 while OFF -> L stays 0; call=1 again while ON -> L stays 1.
- Async reset mid-ON: drive rst=0 between clock edges while L=1 -> L=0 immediately, without waiting for a clk edge. Repeat with SYNC_STAGES=2 -> response to call delayed by exactly 2 extra cycles.

Source files
------------

// File: rtl/flight_call_button_fsm_if.sv
// Cabin-seat call-button panel bus: the two button lines in, the attendant light out.
// The panel side drives the buttons; the controller drives the light.
interface flight_call_button_fsm_if;
  logic call;
  logic cncl;
  logic L;

  modport master (
    output call,
    output cncl,
    input  L
  );

  modport slave (
    input  call,
    input  cncl,
    output L
  );
endinterface

// File: rtl/flight_call_button_fsm.sv
// Flight-attendant call-button controller: call lights L, cancel clears it, call has priority.
// Optional per-input flop chains let raw panel switch lines be used directly.
module flight_call_button_fsm #(
  parameter int unsigned SYNC_STAGES = 0
) (
  input logic                      clk,
  input logic                      rst,
  flight_call_button_fsm_if.slave  bus
);

  typedef enum logic {
    StOff = 1'b0,
    StOn  = 1'b1
  } state_e;

  state_e state_q, state_d;
  logic   call_s;
  logic   cncl_s;

  // Button lines are either already synchronous or pass through a
  // SYNC_STAGES-deep flop chain, each stage adding one cycle of latency.
  if (SYNC_STAGES == 0) begin : g_nosync
    assign call_s = bus.call;
    assign cncl_s = bus.cncl;
  end else begin : g_sync
    logic [SYNC_STAGES-1:0] call_q;
    logic [SYNC_STAGES-1:0] cncl_q;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        call_q <= '0;
        cncl_q <= '0;
      end else begin
        call_q[0] <= bus.call;
        cncl_q[0] <= bus.cncl;
        for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
          call_q[i] <= call_q[i-1];
          cncl_q[i] <= cncl_q[i-1];
        end
      end
    end

    assign call_s = call_q[SYNC_STAGES-1];
    assign cncl_s = cncl_q[SYNC_STAGES-1];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StOff;
    end else begin
      state_q <= state_d;
    end
  end

  // Level-sensitive: call wins over cancel, neither pressed holds the light.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StOff, StOn: begin
        if (call_s) begin
          state_d = StOn;
        end else if (cncl_s) begin
          state_d = StOff;
        end
      end
      default: state_d = StOff;
    endcase
  end

  // Light comes straight off the state flop so it cannot glitch.
  assign bus.L = logic'(state_q);

endmodule

// File: tb/tb_flight_call_button_fsm.sv
// Directed bench for flight_call_button_fsm, running SYNC_STAGES=0 and =2 instances side by side.
// Inputs change 1 ns after a rising edge; outputs are checked at the same point.
module tb_flight_call_button_fsm;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  flight_call_button_fsm_if bus0 ();
  flight_call_button_fsm_if bus2 ();

  flight_call_button_fsm #(.SYNC_STAGES(0)) u_dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  flight_call_button_fsm #(.SYNC_STAGES(2)) u_dut2 (
    .clk (clk),
    .rst (rst),
    .bus (bus2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic c, input logic x);
    bus0.call = c;
    bus0.cncl = x;
    bus2.call = c;
    bus2.cncl = x;
  endtask

  initial begin
    checks = 0;
    errors = 0;

    // Reset held for 20 ns with call pressed
    rst = 1'b0;
    drive(1'b1, 1'b0);
    #1;
    chk("rst_l0_t1", bus0.L, 1'b0);
    chk("rst_l2_t1", bus2.L, 1'b0);
    tick(1);
    chk("rst_l0_e1", bus0.L, 1'b0);
    chk("rst_l2_e1", bus2.L, 1'b0);
    tick(1);
    chk("rst_l0_e2", bus0.L, 1'b0);
    chk("rst_l2_e2", bus2.L, 1'b0);
    #4;
    rst = 1'b1;
    tick(1);
    chk("rel_l0_e1", bus0.L, 1'b1);
    chk("rel_l2_e1", bus2.L, 1'b0);
    tick(1);
    chk("rel_l2_e2", bus2.L, 1'b0);
    tick(1);
    chk("rel_l2_e3", bus2.L, 1'b1);

    // Call released, light holds
    drive(1'b0, 1'b0);
    tick(10);
    chk("hold_l0", bus0.L, 1'b1);
    chk("hold_l2", bus2.L, 1'b1);

    // Cancel from ON
    drive(1'b0, 1'b1);
    tick(1);
    chk("cncl_l0_e1", bus0.L, 1'b0);
    chk("cncl_l2_e1", bus2.L, 1'b1);
    tick(1);
    chk("cncl_l2_e2", bus2.L, 1'b1);
    tick(1);
    chk("cncl_l2_e3", bus2.L, 1'b0);
    tick(3);
    drive(1'b0, 1'b0);
    tick(5);
    chk("cncl_rel_l0", bus0.L, 1'b0);
    chk("cncl_rel_l2", bus2.L, 1'b0);

    // Cancel while OFF does nothing
    drive(1'b0, 1'b1);
    tick(4);
    chk("noop_cncl_l0", bus0.L, 1'b0);
    chk("noop_cncl_l2", bus2.L, 1'b0);
    drive(1'b0, 1'b0);
    tick(3);

    // Sub-period call pulse that misses every rising edge
    drive(1'b1, 1'b0);
    #3;
    drive(1'b0, 1'b0);
    tick(4);
    chk("glitch_l0", bus0.L, 1'b0);
    chk("glitch_l2", bus2.L, 1'b0);

    // Both pressed from OFF, then from ON
    drive(1'b1, 1'b1);
    tick(1);
    chk("prio_off_l0", bus0.L, 1'b1);
    chk("prio_off_l2_e1", bus2.L, 1'b0);
    tick(2);
    chk("prio_off_l2_e3", bus2.L, 1'b1);
    tick(3);
    chk("prio_on_l0", bus0.L, 1'b1);
    chk("prio_on_l2", bus2.L, 1'b1);

    // Release call while cancel still held
    drive(1'b0, 1'b1);
    tick(1);
    chk("prio_rel_l0", bus0.L, 1'b0);
    chk("prio_rel_l2_e1", bus2.L, 1'b1);
    tick(1);
    chk("prio_rel_l2_e2", bus2.L, 1'b1);
    tick(1);
    chk("prio_rel_l2_e3", bus2.L, 1'b0);

    // Repeated call while ON
    drive(1'b1, 1'b0);
    tick(3);
    chk("call_on_l0", bus0.L, 1'b1);
    chk("call_on_l2", bus2.L, 1'b1);
    drive(1'b0, 1'b0);
    tick(2);
    drive(1'b1, 1'b0);
    tick(3);
    chk("recall_l0", bus0.L, 1'b1);
    chk("recall_l2", bus2.L, 1'b1);
    drive(1'b0, 1'b0);
    tick(2);
    chk("recall_rel_l0", bus0.L, 1'b1);
    chk("recall_rel_l2", bus2.L, 1'b1);

    // Asynchronous reset between edges while ON
    #3;
    rst = 1'b0;
    #1;
    chk("arst_l0", bus0.L, 1'b0);
    chk("arst_l2", bus2.L, 1'b0);
    #10;
    rst = 1'b1;
    tick(4);
    chk("arst_rel_l0", bus0.L, 1'b0);
    chk("arst_rel_l2", bus2.L, 1'b0);

    // Post-reset call: two extra cycles through the 2-stage synchronizer
    drive(1'b1, 1'b0);
    tick(1);
    chk("lat_l0_e1", bus0.L, 1'b1);
    chk("lat_l2_e1", bus2.L, 1'b0);
    tick(1);
    chk("lat_l2_e2", bus2.L, 1'b0);
    tick(1);
    chk("lat_l2_e3", bus2.L, 1'b1);
    drive(1'b0, 1'b0);
    tick(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
